// File: rtl/video_packer.sv
// ---------------------------------------------------------------------------------------------
// video_packer
//   Front end of the video pack interface. Samples single-clock DVP-style video, tracks the
//   pixel column/line, and emits one registered pack word per clock (1-cycle latency) once
//   the packer has locked to a frame boundary. Short lines and frames with the wrong line
//   count are flagged with one-cycle error pulses.
//
// Parameters
//   H_ACT   active pixels per line
//   V_ACT   active lines per frame
//   VS_POL  active level of i_vs
//
// Ports
//   clk      pixel clock
//   rst      asynchronous reset, active-high
//   en       packing enable; low forces IDLE from the next cycle
//   i_vs     vertical sync (raw level, polarity per VS_POL)
//   i_hs     horizontal sync, passed through
//   i_de     data enable
//   i_rgb    {r[7:0], g[7:0], b[7:0]}
//   o_pack   {r,g,b, vs, hs, de, sof, x[XW], y[YW]}, zero unless locked
//   h_err    pulse: completed line had fewer than H_ACT active pixels
//   v_err    pulse: completed frame did not contain V_ACT lines
//   locked   high while in RUN
// ---------------------------------------------------------------------------------------------
module video_packer #(
    parameter logic [11:0] H_ACT  = 12'd1280,
    parameter logic [11:0] V_ACT  = 12'd720,
    parameter logic        VS_POL = 1'b1,
    localparam int XW        = $clog2(H_ACT),
    localparam int YW        = $clog2(V_ACT),
    localparam int PACK_SIZE = 3 * 8 + 4 + XW + YW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 i_vs,
    input  logic                 i_hs,
    input  logic                 i_de,
    input  logic [23:0]          i_rgb,
    output logic [PACK_SIZE-1:0] o_pack,
    output logic                 h_err,
    output logic                 v_err,
    output logic                 locked
);

    // Counter limits. xc saturates at H_ACT so an overlong line reads as exactly H_ACT;
    // yc saturates one past V_ACT so an extra line is still distinguishable from a full frame.
    localparam logic [XW:0]   X_SAT    = H_ACT[XW:0];
    localparam logic [XW:0]   X_LAST   = X_SAT - 1'b1;
    localparam logic [XW-1:0] X_LAST_F = X_LAST[XW-1:0];
    localparam logic [YW:0]   Y_FULL   = V_ACT[YW:0];
    localparam logic [YW:0]   Y_SAT    = Y_FULL + 1'b1;
    localparam logic [YW:0]   Y_LAST   = Y_FULL - 1'b1;
    localparam logic [YW-1:0] Y_LAST_F = Y_LAST[YW-1:0];

    typedef enum logic [1:0] {
        StIdle,
        StWaitVs,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic                   vs_q, de_q;
    logic [XW:0]            xc_q, xc_d;
    logic [YW:0]            yc_q, yc_d;
    logic [PACK_SIZE-1:0]   pack_q, pack_d;
    logic                   h_err_q, h_err_d;
    logic                   v_err_q, v_err_d;
    logic                   locked_q, locked_d;

    logic                   vs_act;
    logic                   vs_rise;
    logic                   de_fall;
    logic                   pack_act;
    logic                   in_run;
    logic [YW:0]            yc_done;
    logic [YW:0]            y_cur;
    logic [XW-1:0]          x_fld;
    logic [YW-1:0]          y_fld;
    logic                   sof;

    // ---------------------------------------------------------------------------------------
    // Edge detection on the polarity-normalised vsync and on de
    // ---------------------------------------------------------------------------------------
    assign vs_act  = (i_vs == VS_POL);
    assign vs_rise = vs_act & ~vs_q;
    assign de_fall = de_q & ~i_de;

    // ---------------------------------------------------------------------------------------
    // Column / line counters. They track the incoming video in every state so that the
    // coordinates are already correct on the cycle that locks.
    // ---------------------------------------------------------------------------------------
    always_comb begin
        xc_d = xc_q;
        if (!i_de) begin
            xc_d = '0;
        end else if (xc_q != X_SAT) begin
            xc_d = xc_q + 1'b1;
        end
    end

    always_comb begin
        // Line count including a line that completes this cycle; a coincident vs_rise checks
        // this value before clearing the counter.
        yc_done = yc_q;
        if (de_fall && (yc_q != Y_SAT)) begin
            yc_done = yc_q + 1'b1;
        end
        yc_d = vs_rise ? '0 : yc_done;
    end

    // ---------------------------------------------------------------------------------------
    // Coordinate fields
    // ---------------------------------------------------------------------------------------
    always_comb begin
        x_fld = '0;
        if (i_de) begin
            x_fld = (xc_q > X_LAST) ? X_LAST_F : xc_q[XW-1:0];
        end
        y_cur = vs_rise ? '0 : yc_q;
        y_fld = (y_cur > Y_LAST) ? Y_LAST_F : y_cur[YW-1:0];
        sof   = i_de && (x_fld == '0) && (y_fld == '0);
    end

    // ---------------------------------------------------------------------------------------
    // State machine and registered outputs
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (en) state_d = StWaitVs;
            StWaitVs: if (vs_rise) state_d = StRun;
            StRun:    state_d = StRun;
            default:  state_d = StIdle;
        endcase
        if (!en) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        // The locking vs_rise cycle is already packed as RUN, so packing follows state_d.
        pack_act = (state_d == StRun);
        // Error checks only apply once locked; the locking vs_rise itself is excluded.
        in_run   = en && (state_q == StRun);

        pack_d   = '0;
        if (pack_act) begin
            pack_d = {i_rgb, i_vs, i_hs, i_de, sof, x_fld, y_fld};
        end
        h_err_d  = in_run && de_fall && (xc_q != X_SAT);
        v_err_d  = in_run && vs_rise && (yc_done != Y_FULL);
        locked_d = pack_act;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            vs_q     <= 1'b0;
            de_q     <= 1'b0;
            xc_q     <= '0;
            yc_q     <= '0;
            pack_q   <= '0;
            h_err_q  <= 1'b0;
            v_err_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= vs_act;
            de_q     <= i_de;
            xc_q     <= xc_d;
            yc_q     <= yc_d;
            pack_q   <= pack_d;
            h_err_q  <= h_err_d;
            v_err_q  <= v_err_d;
            locked_q <= locked_d;
        end
    end

    assign o_pack = pack_q;
    assign h_err  = h_err_q;
    assign v_err  = v_err_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_video_packer.sv
// ---------------------------------------------------------------------------------------------
// tb_video_packer
//   Two packers (VS_POL=1 and VS_POL=0) see the same video, the second with inverted vsync.
//   Stimulus is built from frame-level tasks (vsync pulses, lines of given length); the
//   expected pack word and error pulses for each input cycle are derived from the frame
//   structure the tasks are generating.
// ---------------------------------------------------------------------------------------------
module tb_video_packer;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int PW = 33;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          vs;
    logic          hs;
    logic          de;
    logic [23:0]   rgb;
    logic          vs_inv;
    logic [PW-1:0] pack_p, pack_n;
    logic          h_err_p, h_err_n, v_err_p, v_err_n, locked_p, locked_n;

    assign vs_inv = ~vs;

    video_packer #(.H_ACT(12'd8), .V_ACT(12'd4), .VS_POL(1'b1)) dut_p (
        .clk(clk), .rst(rst), .en(en), .i_vs(vs), .i_hs(hs), .i_de(de), .i_rgb(rgb),
        .o_pack(pack_p), .h_err(h_err_p), .v_err(v_err_p), .locked(locked_p)
    );

    video_packer #(.H_ACT(12'd8), .V_ACT(12'd4), .VS_POL(1'b0)) dut_n (
        .clk(clk), .rst(rst), .en(en), .i_vs(vs_inv), .i_hs(hs), .i_de(de), .i_rgb(rgb),
        .o_pack(pack_n), .h_err(h_err_n), .v_err(v_err_n), .locked(locked_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level model: lock phase (0 idle, 1 waiting for vsync, 2 running),
    // lines completed in the current frame, enable level, and rgb pattern choice.
    int run   = 0;
    int lines = 0;
    bit en_v  = 1'b0;
    bit nominal = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One input cycle. col/line are the true position in the video; rise marks a vsync
    // leading edge; he/ve mark a short line ending / miscounted frame ending on this cycle.
    task automatic tick(input logic v, input logic h, input logic d, input logic [23:0] c,
                        input bit rise, input int col, input int line, input bit he,
                        input bit ve);
        bit            e, pk, act, sof;
        int            xv, yv;
        logic [2:0]    xb;
        logic [1:0]    yb;
        logic [PW-1:0] exp_p, exp_n;
        e   = en_v;
        pk  = e && (run == 2 || (run == 1 && rise));
        act = e && (run == 2);
        en  = e;
        vs  = v;
        hs  = h;
        de  = d;
        rgb = c;
        @(posedge clk);
        #1;
        xv  = !d ? 0 : (col > H - 1 ? H - 1 : col);
        yv  = rise ? 0 : (line > V - 1 ? V - 1 : line);
        sof = d && xv == 0 && yv == 0;
        xb  = xv[2:0];
        yb  = yv[1:0];
        exp_p = pk ? {c, v, h, d, sof, xb, yb} : '0;
        exp_n = pk ? {c, ~v, h, d, sof, xb, yb} : '0;
        chk("pack_pol1", 64'(pack_p), 64'(exp_p));
        chk("pack_pol0", 64'(pack_n), 64'(exp_n));
        chk("h_err_pol1", 64'(h_err_p), 64'(he && act));
        chk("h_err_pol0", 64'(h_err_n), 64'(he && act));
        chk("v_err_pol1", 64'(v_err_p), 64'(ve && act));
        chk("v_err_pol0", 64'(v_err_n), 64'(ve && act));
        chk("locked_pol1", 64'(locked_p), 64'(pk));
        chk("locked_pol0", 64'(locked_n), 64'(pk));
        if (!e) run = 0;
        else if (run == 0) run = 1;
        else if (run == 1 && rise) run = 2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'($urandom), 1'b0, 24'($urandom), 1'b0, 0, lines, 1'b0, 1'b0);
        end
    endtask

    // A line of n active pixels followed by blank cycles; blank==0 leaves de high so the
    // next task ends the line. kill>=0 drops en at that pixel.
    task automatic line(input int n, input int blank, input int kill);
        logic [23:0] c;
        for (int i = 0; i < n; i++) begin
            if (kill == i) en_v = 1'b0;
            c = nominal ? 24'h010203 + 24'(i) : 24'($urandom);
            tick(1'b0, 1'b0, 1'b1, c, 1'b0, i, lines, 1'b0, 1'b0);
        end
        if (blank > 0) begin
            tick(1'b0, 1'b1, 1'b0, 24'($urandom), 1'b0, 0, lines, n < H, 1'b0);
            lines++;
            for (int i = 1; i < blank; i++) begin
                tick(1'b0, 1'($urandom), 1'b0, 24'($urandom), 1'b0, 0, lines, 1'b0, 1'b0);
            end
        end
    endtask

    // Vsync pulse of len cycles then low cycles. fall_n>0: the previous line (of that
    // length) ends on the vsync leading-edge cycle.
    task automatic vsync(input int len, input int low, input int fall_n);
        int done;
        done = lines + (fall_n > 0 ? 1 : 0);
        tick(1'b1, 1'($urandom), 1'b0, 24'($urandom), 1'b1, 0, 0,
             fall_n > 0 && fall_n < H, done != V);
        lines = 0;
        for (int i = 1; i < len; i++) begin
            tick(1'b1, 1'($urandom), 1'b0, 24'($urandom), 1'b0, 0, lines, 1'b0, 1'b0);
        end
        idle(low);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        vs  = 1'b0;
        hs  = 1'b0;
        de  = 1'b0;
        rgb = '0;
        @(posedge clk);
        #1;
        chk("reset_pack", 64'(pack_p), 64'd0);
        chk("reset_lock", 64'(locked_p), 64'd0);
        chk("reset_herr", 64'(h_err_n), 64'd0);
        chk("reset_verr", 64'(v_err_n), 64'd0);
        rst = 1'b0;

        // Nominal frame with counting rgb
        en_v    = 1'b1;
        nominal = 1'b1;
        idle(3);
        vsync(2, 3, 0);
        for (int l = 0; l < V; l++) line(H, 3, -1);
        vsync(2, 3, 0);
        nominal = 1'b0;

        // Short second line; line count still correct
        line(H, 3, -1);
        line(H - 2, 3, -1);
        line(H, 3, -1);
        line(H, 3, -1);
        vsync(2, 3, 0);

        // Five lines: y saturates, v_err at next vsync
        for (int l = 0; l < V + 1; l++) line(H, 2, -1);
        vsync(1, 2, 0);

        // Lock sequence: enable mid-frame, partial/short lines must not flag
        en_v = 1'b0;
        idle(2);
        line(H, 3, -1);
        en_v = 1'b1;
        line(H - 3, 2, -1);
        line(H, 2, -1);
        vsync(2, 3, 0);
        for (int l = 0; l < V; l++) line(H, 2, -1);

        // Disable at x=3, then relock
        line(H, 3, 3);
        en_v = 1'b1;
        line(H, 2, -1);
        vsync(2, 2, 0);
        line(H, 2, -1);
        line(4, 0, -1);

        // Asynchronous reset mid-line
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pack_pol1", 64'(pack_p), 64'd0);
        chk("async_rst_pack_pol0", 64'(pack_n), 64'd0);
        chk("async_rst_lock", 64'(locked_p), 64'd0);
        de = 1'b0;
        vs = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_pack", 64'(pack_p), 64'd0);
        chk("rst_hold_lock", 64'(locked_n), 64'd0);
        rst   = 1'b0;
        run   = 0;
        lines = 0;
        idle(2);
        line(H, 2, -1);
        vsync(2, 2, 0);
        for (int l = 0; l < V - 1; l++) line(H, 3, -1);

        // Coincidence: last line's de_fall on the vsync edge, correct count
        line(H, 0, -1);
        vsync(3, 3, H);
        line(H, 3, -1);
        // Coincidence with a short last line and a short frame
        line(H, 3, -1);
        line(5, 0, -1);
        vsync(2, 3, 5);

        // Random frames: line lengths and counts around nominal
        for (int f = 0; f < 4; f++) begin
            int nl;
            nl = V - 1 + int'($urandom_range(0, 2));
            for (int l = 0; l < nl; l++) begin
                line(H - 2 + int'($urandom_range(0, 4)), 1 + int'($urandom_range(0, 3)), -1);
            end
            vsync(1 + int'($urandom_range(0, 2)), 2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_packer.md
Name: video_packer

Overview:
- Front end of the video pack interface: samples raw single-clock DVP-style video (vs, hs, de, 24-bit RGB) and emits the packed bus consumed by the line-buffer and downstream pixel modules.
- Tracks the pixel column and line coordinates and inserts them into the pack.
- Aligns packing to frame boundaries and flags malformed lines and frames.

Parameters:
- H_ACT, 12'd1280, active pixels per line.
- V_ACT, 12'd720, active lines per frame.
- VS_POL, 1'b1, vsync active level.
- XW (localparam), $clog2(H_ACT), x field width.
- YW (localparam), $clog2(V_ACT), y field width.
- PACK_SIZE (localparam), 3*8+4+XW+YW, pack width.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  packing enable
- i_vs  in  1  vertical sync, level per VS_POL
- i_hs  in  1  horizontal sync, passed through
- i_de  in  1  data enable
- i_rgb  in  24  {r[7:0], g[7:0], b[7:0]}
- o_pack  out  PACK_SIZE  packed pixel; MSB to LSB: {r,g,b}[24], vs, hs, de, sof, x[XW], y[YW]
- h_err  out  1  one-cycle pulse: line had wrong active length
- v_err  out  1  one-cycle pulse: frame had wrong line count
- locked  out  1  high while in RUN

Behaviour:
- Reset (async, rst=1): state IDLE; o_pack=0, h_err=0, v_err=0, locked=0; all counters and edge registers cleared.
- Edge detection:
  - vs is normalised to active-high via VS_POL.
  - vs_rise = vs active now and not active the previous cycle.
  - de_fall = de was 1 the previous cycle and is 0 now.
- State machine, evaluated each clk:
  - IDLE: entered on en=0 from any state, effective next cycle. Leaves to WAIT_VS when en=1.
  - WAIT_VS: leaves to RUN on vs_rise. The vs_rise cycle itself is packed as RUN with y=0.
  - RUN: stays until en=0.
- Output in IDLE and WAIT_VS: o_pack=0, no error pulses.
- Latency in RUN: exactly 1 cycle. o_pack at cycle t+1 reflects inputs at cycle t. RGB, vs (raw level), hs and de are copied unchanged.
- Column counter xc (XW+1 bits):
  - Zeroed whenever de=0.
  - Increments on each de=1 cycle, saturating at H_ACT.
  - x field = min(xc, H_ACT-1) sampled before the increment, so the first active pixel has x=0.
  - x field = 0 when de=0.
- Line counter yc (YW+1 bits):
  - Zeroed on vs_rise.
  - Increments on de_fall, saturating at V_ACT+1.
  - y field = min(yc, V_ACT-1) on every RUN cycle, whether or not de=1.
- sof = 1 only when de=1 and x==0 and y==0 (first pixel of the frame).
- h_err:
  - Evaluated in RUN on de_fall, where xc is the completed line length.
  - If xc != H_ACT, h_err=1 the following cycle, aligned with the o_pack word that carries de=0.
  - A line longer than H_ACT saturates and reports as xc==H_ACT. Overlong lines are therefore not flagged; only short lines are.
- v_err:
  - Evaluated in RUN on vs_rise, excluding the first vs_rise after WAIT_VS.
  - If yc != V_ACT, v_err=1 the following cycle.
- Simultaneous de_fall and vs_rise: the line is completed and checked first. The v_err check uses yc+1 (the completed line), then yc is set to 0.
- de high during vs_rise: the pixel is packed normally with y=0.
- en deasserted mid-line: o_pack=0 from the next cycle. No h_err/v_err is emitted for the partial line or frame. Re-enable always waits for a fresh vs_rise.
- rst mid-frame: immediate zeroing; same re-lock rule as en deassertion.
- locked = 1 in RUN, registered (rises the cycle after vs_rise).

Test Plan:
1. Nominal frame (H_ACT=8, V_ACT=4, VS_POL=1):
   - Stimulus: en=1; vs pulse; 4 lines of 8 de cycles, 3 blanking cycles between lines, rgb=24'h010203+col; second vs pulse.
   - Required: o_pack 1 cycle late; x runs 0..7 and y 0..3; sof only on (0,0); h_err=0 and v_err=0 throughout; locked=1.
2. Short line (same parameters):
   - Stimulus: line 2 has 6 de cycles.
   - Required: h_err pulses once, 1 cycle after that line's de_fall (on the output word with de=0). At the next vs_rise there are still 4 lines, so v_err=0.
3. Wrong line count:
   - Stimulus: 5 lines between two vs pulses.
   - Required: line 5 has y saturated at 3; v_err pulses 1 cycle after the second vs_rise.
4. Lock sequence:
   - Stimulus: en=1 asserted mid-frame with de toggling.
   - Required: o_pack=0 and locked=0 until the first vs_rise; no error pulses from the partial frame.
5. Disable and reset mid-line:
   - Stimulus: en=0 at pixel x=3; later rst=1 pulse while in RUN.
   - Required: o_pack=0 starting the next cycle; rst clears o_pack asynchronously in the same cycle; after either, re-lock requires a new vs_rise.
6. Polarity and coincidence:
   - Stimulus: VS_POL=0; vs falling edge coincides with de_fall of line 4.
   - Required: v_err=0 (yc+1 rule applied); next frame starts at y=0.
